// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a single-port data memory.
// Takes one access at a time, handles byte lanes and alignment, and extends load data.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memOp,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic [31:0] memOut,
  output logic        readValid,
  output logic        stall,
  output logic        misaligned
);

  // state | meaning
  // IDLE  | waiting for an aligned load/store
  // BUSY  | memReq held until memAck
  // RESP  | one-cycle release; readValid for loads
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        load_q;

  logic        op_valid;
  logic        op_load;
  logic        mis_cond;
  logic        accept;
  size_t       size_in;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  function automatic size_t size_of(input logic [2:0] f);
    size_t s;
    case (f)
      3'b000, 3'b100: s = SZ_BYTE;
      3'b001, 3'b101: s = SZ_HALF;
      default:        s = SZ_WORD;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] lo,
                                          input logic [31:0] rd);
    logic [31:0] shifted;
    logic [15:0] half;
    logic        sign_ok;
    logic [31:0] res;
    shifted = rd >> {lo, 3'b000};
    half    = lo[1] ? rd[31:16] : rd[15:0];
    sign_ok = ~f[2];
    case (size_of(f))
      SZ_BYTE: res = {{24{sign_ok & shifted[7]}}, shifted[7:0]};
      SZ_HALF: res = {{16{sign_ok & half[15]}}, half};
      default: res = rd;
    endcase
    return res;
  endfunction

  assign size_in  = size_of(funct3);
  assign op_load  = (memOp == 2'b01);
  assign op_valid = (memOp == 2'b01) || (memOp == 2'b10);

  always_comb begin
    mis_cond = 1'b0;
    case (size_in)
      SZ_HALF: mis_cond = addr[0];
      SZ_WORD: mis_cond = (addr[1:0] != 2'b00);
      default: mis_cond = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && op_valid && !mis_cond;

  // Gated by reset so a held request cannot raise stall while reset is asserted.
  assign stall      = !reset && (accept || (state == BUSY));
  assign misaligned = !reset && (state == IDLE) && op_valid && mis_cond;

  always_comb begin
    store_be    = 4'b1111;
    store_wdata = storeData;
    case (size_in)
      SZ_BYTE: begin
        store_be    = 4'b0001 << addr[1:0];
        store_wdata = {4{storeData[7:0]}};
      end
      SZ_HALF: begin
        store_be    = addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{storeData[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = storeData;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      load_q    <= 1'b0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= 32'h0;
      memBe     <= 4'b0000;
      memWdata  <= 32'h0;
      memOut    <= 32'h0;
      readValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          readValid <= 1'b0;
          if (accept) begin
            funct3_q  <= funct3;
            addr_lo_q <= addr[1:0];
            load_q    <= op_load;
            memReq    <= 1'b1;
            memWe     <= !op_load;
            memAddr   <= {addr[31:2], 2'b00};
            memBe     <= op_load ? 4'b1111 : store_be;
            memWdata  <= op_load ? 32'h0 : store_wdata;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (memAck) begin
            memReq    <= 1'b0;
            readValid <= load_q;
            if (load_q)
              memOut <= extract(funct3_q, addr_lo_q, memRdata);
            state     <= RESP;
          end
        end
        RESP: begin
          readValid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          memReq    <= 1'b0;
          readValid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized accesses against a byte-lane reference model of the load/store unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memOp;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic        memAck;
  logic [31:0] memRdata;
  logic [31:0] memOut;
  logic        readValid;
  logic        stall;
  logic        misaligned;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_out = 32'h0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .memOp(memOp), .funct3(funct3), .addr(addr),
    .storeData(storeData), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memBe(memBe), .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata),
    .memOut(memOut), .readValid(readValid), .stall(stall), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    if (f == 3'd0 || f == 3'd4) return 1;
    if (f == 3'd1 || f == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f, input logic [31:0] a);
    int n = nbytes(f);
    return 32'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] sd);
    int n = nbytes(f);
    if (n == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n = nbytes(f);
    logic [31:0] v = rd >> ((a % 4) * 8);
    if (n == 1) begin
      v = v & 32'hFF;
      if (f == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'hFFFF;
      if (f == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One full access: request held through BUSY and RESP, dropped in the IDLE after.
  task automatic access(input logic [1:0] op, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int dly);
    bit is_ld = (op == 2'b01);
    bit is_st = (op == 2'b10);
    bit valid = is_ld || is_st;
    bit mis   = valid && ((a % nbytes(f)) != 0);
    int stalls = 0;
    @(negedge clk);
    memOp = op; funct3 = f; addr = a; storeData = sd; memAck = 1'b0; memRdata = $urandom;
    #1;
    check("misaligned_flag", 32'(misaligned), 32'(mis));
    check("req_idle", 32'(memReq), 0);
    if (!valid || mis) begin
      check("stall_reject", 32'(stall), 0);
      check("rv_reject", 32'(readValid), 0);
      @(posedge clk); #1;
      check("req_after_reject", 32'(memReq), 0);
      memOp = 2'b00;
      #1;
      check("misaligned_pulse_end", 32'(misaligned), 0);
      check("out_hold_reject", memOut, exp_out);
      return;
    end
    check("stall_accept", 32'(stall), 1);
    if (stall) stalls++;
    @(posedge clk);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      memAck   = (i == dly);
      memRdata = (i == dly) ? rd : $urandom;
      #1;
      check("req_busy", 32'(memReq), 1);
      check("we_busy", 32'(memWe), 32'(is_st));
      check("addr_busy", memAddr, a & 32'hFFFF_FFFC);
      check("be_busy", 32'(memBe), is_ld ? 32'hF : model_be(f, a));
      if (is_st) check("wdata_busy", memWdata, model_wdata(f, sd));
      check("rv_busy", 32'(readValid), 0);
      if (stall) stalls++;
      @(posedge clk);
    end
    @(negedge clk);
    memAck = 1'($urandom_range(0, 1));
    memRdata = $urandom;
    #1;
    if (is_ld) exp_out = model_load(f, a, rd);
    check("req_resp", 32'(memReq), 0);
    check("stall_resp", 32'(stall), 0);
    check("rv_resp", 32'(readValid), 32'(is_ld));
    check("out_resp", memOut, exp_out);
    @(posedge clk);
    @(negedge clk);
    memOp = 2'b00; memAck = 1'b0;
    #1;
    check("rv_after", 32'(readValid), 0);
    check("req_after", 32'(memReq), 0);
    check("stall_after", 32'(stall), 0);
    check("out_hold", memOut, exp_out);
    check("stall_cycles", stalls, dly + 2);
  endtask

  initial begin
    reset = 1'b1; memOp = 2'b00; funct3 = 3'b000; addr = 32'h0; storeData = 32'h0;
    memAck = 1'b0; memRdata = 32'h0;
    #12;
    check("rst_req", 32'(memReq), 0);
    check("rst_be", 32'(memBe), 0);
    check("rst_addr", memAddr, 0);
    check("rst_out", memOut, 0);
    check("rst_stall", 32'(stall), 0);
    @(negedge clk);
    reset = 1'b0;

    access(2'b01, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 1);
    check("lb_result", memOut, 32'hFFFF_FF80);
    access(2'b10, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 0);
    access(2'b01, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0);
    access(2'b01, 3'b101, 32'h0000_4002, 32'h0, 32'hF00D_0000, 0);
    check("lhu_result", memOut, 32'h0000_F00D);

    // Reset in the middle of a pending load, with the request still driven.
    @(negedge clk);
    memOp = 2'b01; funct3 = 3'b010; addr = 32'h0000_5000;
    @(posedge clk);
    @(negedge clk); #1;
    check("busy_before_rst", 32'(memReq), 1);
    reset = 1'b1;
    #1;
    exp_out = 32'h0;
    check("rst_mid_req", 32'(memReq), 0);
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_be", 32'(memBe), 0);
    check("rst_mid_out", memOut, 0);
    check("rst_mid_rv", 32'(readValid), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; memOp = 2'b00; memAck = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("rst_release_rv", 32'(readValid), 0);
    check("rst_release_req", 32'(memReq), 0);
    memAck = 1'b0;
    access(2'b01, 3'b010, 32'h0000_6004, 32'h0, 32'hDEAD_BEEF, 2);
    check("lw_after_rst", memOut, 32'hDEAD_BEEF);

    access(2'b10, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 32'h0, 1);
    access(2'b01, 3'b010, 32'h0000_7000, 32'h0, 32'h0BAD_CAFE, 0);
    access(2'b00, 3'b010, 32'h0000_8000, 32'h0, 32'h0, 0);
    access(2'b11, 3'b000, 32'h0000_8001, 32'h0, 32'h0, 0);

    for (int n = 0; n < 80; n++) begin
      logic [1:0] op;
      logic [2:0] f;
      op = 2'($urandom_range(0, 3));
      f  = (op == 2'b10) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      access(op, f, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
